fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL expose parameter Data_Width, default 8, meaning the FIFO word and output data width in bits.
REQ-002 SHALL expose parameter Cnt_Width, default 16, meaning the beat counter width in bits.
REQ-003 SHALL use one clock and a synchronous, active-high reset; no other clock or reset exists.
REQ-004 SHALL provide these ports (name, direction, width, meaning):
- rd_clk  input  1  read-domain clock.
- rd_rst  input  1  synchronous active-high reset.
- empty  input  1  FIFO empty flag.
- data_out  input  Data_Width  FIFO read data, valid one rd_clk after rd_en.
- rd_en  output  1  FIFO pop request.
- flush  input  1  discard all buffered and in-flight words.
- out_valid  output  1  output beat available.
- out_ready  input  1  downstream accepts beat.
- out_data  output  Data_Width  output beat data.
- beat_cnt  output  Cnt_Width  count of accepted output beats.
- busy  output  1  state is not IDLE.

Function
REQ-005 SHALL hold a 2-entry internal buffer with occupancy occ (0..2) and an inflight bit equal to rd_en of the previous cycle.
REQ-006 SHALL define pop = out_valid && out_ready; an output beat is transferred only on pop.
REQ-007 SHALL drive rd_en combinationally as !empty && !flush && state!=FLUSH && (occ + inflight - pop) < 2, so rd_en is never asserted while empty=1.
REQ-008 SHALL write data_out into the buffer tail at the rising edge that ends any cycle with inflight=1, unless state is FLUSH.
REQ-009 SHALL drive out_valid = (occ != 0) and out_data = buffer head; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-010 SHALL handle a simultaneous pop and capture in one cycle with occ unchanged and FIFO order preserved.
REQ-011 SHALL give a latency of 2 cycles: with empty falling in cycle N and the buffer empty, out_valid rises in cycle N+2.
REQ-012 SHALL sustain one beat per cycle when empty=0 and out_ready=1 are held.
REQ-013 SHALL increment beat_cnt by 1 on each pop, wrapping from all-ones to 0.
REQ-014 SHALL implement states IDLE, ACTIVE and FLUSH:
- IDLE -> ACTIVE when rd_en=1.
- ACTIVE -> IDLE when occ and inflight both reach 0 with rd_en=0.
- Any state with flush=1 -> FLUSH if rd_en was asserted this cycle or inflight=1, else -> IDLE.
- FLUSH -> IDLE after exactly one cycle.
REQ-015 SHALL clear occ to 0 at the edge ending a flush=1 cycle; a pop in that same cycle is still counted in beat_cnt.
REQ-016 SHALL discard, in FLUSH, the word arriving on data_out, and SHALL hold out_valid=0 throughout FLUSH.
REQ-017 SHALL treat flush asserted in consecutive cycles as repeated flushes; the block remains in FLUSH or IDLE until flush deasserts.

Reset
REQ-018 SHALL, on rd_rst=1 at a rising edge, set state=IDLE, occ=0, inflight=0 and beat_cnt=0.
REQ-019 SHALL force rd_en=0 combinationally while rd_rst=1.
REQ-020 SHALL, one cycle after reset, show out_valid=0, busy=0 and beat_cnt=0; out_data is don't-care while out_valid=0.
REQ-021 SHALL, on reset asserted mid-transfer, drop any in-flight word exactly as a flush does.

Configuration
REQ-022 SHALL, with macro RD_PARITY_EN defined, add output port out_parity (1 bit), the even parity (XOR reduction) of out_data, computed at capture and stored per buffer entry.
REQ-023 SHALL, without RD_PARITY_EN, omit the out_parity port and its storage; all other behaviour is identical.

Verification
REQ-024 SHALL cover basic latency: reset, then empty=0 with data_out=0xA5 from cycle 0 and out_ready=1 -> rd_en=1 in cycle 0, out_valid=1 with out_data=0xA5 in cycle 2, beat_cnt=1 in cycle 3.
REQ-025 SHALL cover backpressure: FIFO holding 0x01..0x04, out_ready=0 -> rd_en pulses exactly twice, out_data stays 0x01; then out_ready=1 -> 0x01, 0x02, 0x03, 0x04 in order on consecutive cycles, with no loss or duplication.
REQ-026 SHALL cover flush with a word in flight: flush=1 in the cycle after rd_en=1 -> state FLUSH for one cycle, the arriving word is discarded, out_valid=0 for 2 cycles, busy=0 afterwards.
REQ-027 SHALL cover counter wrap: with Cnt_Width=4, 17 accepted beats -> beat_cnt reads 0xF, then 0x0, then 0x1.
REQ-028 SHALL cover mid-transfer reset and parity: rd_rst=1 with occ=2 -> out_valid=0 and beat_cnt=0 next cycle; with RD_PARITY_EN defined, data 0x07 -> out_parity=1 and data 0x03 -> out_parity=0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a FIFO read port (one-cycle read latency) into a
// valid/ready stream through a 2-entry skid buffer, with flush and a beat
// counter.
// Optional feature: define RD_PARITY_EN to add out_parity, the XOR reduction of
// out_data. It is computed when a word is captured and stored with each entry.
module fifo_rd_stream #(
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Cnt_Width  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  empty,
  input  logic [Data_Width-1:0] data_out,
  output logic                  rd_en,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [Data_Width-1:0] out_data,
  output logic [Cnt_Width-1:0]  beat_cnt,
`ifdef RD_PARITY_EN
  output logic                  out_parity,
`endif
  output logic                  busy
);

`ifdef RD_PARITY_EN
  localparam int unsigned EntWidth = Data_Width + 1;
`else
  localparam int unsigned EntWidth = Data_Width;
`endif

  typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

  state_e               state_q, state_d;
  logic [1:0]           occ_q, occ_d;
  logic                 inflight_q;
  logic [EntWidth-1:0]  ent0_q, ent0_d;  // head
  logic [EntWidth-1:0]  ent1_q, ent1_d;
  logic [Cnt_Width-1:0] beat_cnt_q, beat_cnt_d;

  logic                pop;
  logic                capture;
  logic [2:0]          pending;
  logic [EntWidth-1:0] cap_word;

  assign pop     = out_valid && out_ready;
  // The word requested last cycle lands now; in FLUSH it is dropped.
  assign capture = inflight_q && (state_q != StFlush);

`ifdef RD_PARITY_EN
  assign cap_word   = {^data_out, data_out};
  assign out_parity = ent0_q[Data_Width];
`else
  assign cap_word   = data_out;
`endif

  // Words held plus words on the way, less the one leaving this cycle.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Request a FIFO word only when a buffer slot is guaranteed for it.
  assign rd_en = !rd_rst && !empty && !flush && (state_q != StFlush) && (pending < 3'd2);

  assign out_valid = (occ_q != 2'd0) && (state_q != StFlush);
  assign out_data  = ent0_q[Data_Width-1:0];
  assign beat_cnt  = beat_cnt_q;
  assign busy      = (state_q != StIdle);

  // Buffer next state: shift out on pop, append on capture, clear on flush.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({pop, capture})
      2'b10: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) begin
          ent0_d = cap_word;
        end else begin
          ent1_d = cap_word;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new word goes behind whatever remains.
        if (occ_q == 2'd1) begin
          ent0_d = cap_word;
        end else begin
          ent0_d = ent1_q;
          ent1_d = cap_word;
        end
      end
      default: ;
    endcase
    if (flush) begin
      occ_d = 2'd0;
    end
  end

  // Beat counter wraps naturally; a pop in a flush cycle still counts.
  always_comb begin
    beat_cnt_d = beat_cnt_q + Cnt_Width'(pop);
  end

  // State next state: flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = (rd_en || inflight_q) ? StFlush : StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (rd_en) state_d = StActive;
        StActive: if ((occ_q == 2'd0) && !inflight_q && !rd_en) state_d = StIdle;
        StFlush:  state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Control registers with synchronous reset; reset drops in-flight words.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= StIdle;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= rd_en;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Buffer storage needs no reset; occupancy qualifies it.
  always_ff @(posedge rd_clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream. A small source-FIFO model answers rd_en
// with data one clock later. Inputs change #1 after posedge; outputs are
// checked on the following negedge.
module tb_fifo_rd_stream;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       empty;
  logic [7:0] data_out = 8'h00;
  logic       rd_en;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] beat_cnt;
  logic       busy;
`ifdef RD_PARITY_EN
  logic       out_parity;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] src_mem [0:63];
  int         src_wr = 0;
  int         src_rd = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(
    .Data_Width(8),
    .Cnt_Width (4)
  ) dut (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .empty     (empty),
    .data_out  (data_out),
    .rd_en     (rd_en),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .beat_cnt  (beat_cnt),
`ifdef RD_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy      (busy)
  );

  // Source FIFO model: one-cycle read latency.
  assign empty = (src_rd == src_wr);
  always @(posedge rd_clk) begin
    if (rd_en) begin
      data_out <= src_mem[src_rd[5:0]];
      src_rd   <= src_rd + 1;
    end
  end

  task automatic push(input logic [7:0] w);
    src_mem[src_wr[5:0]] = w;
    src_wr = src_wr + 1;
  endtask

  task automatic next_cycle();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rd_rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    src_wr = src_rd;
    next_cycle();
    rd_rst = 1'b0;
  endtask

  task automatic test_reset();
    rd_rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    push(8'h3C);
    next_cycle();
    next_cycle();
    @(negedge rd_clk);
    n_cmp++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en_forced: got %b want 0", rd_en); end
    src_wr = src_rd;
    next_cycle();
    rd_rst = 1'b0;
    @(negedge rd_clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (beat_cnt !== 4'h0) begin n_fail++; $display("FAIL rst_beat_cnt: got %h want 0", beat_cnt); end
  endtask

  task automatic test_latency();
    do_reset();
    push(8'hA5);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge rd_clk);
      if (c == 0) begin
        n_cmp++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL lat_rd_en_c0: got %b want 1", rd_en); end
      end
      if (c == 1) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_valid_c1: got %b want 0", out_valid); end
      end
      if (c == 2) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
          n_fail++; $display("FAIL lat_beat_c2: got valid=%b data=%h want valid=1 data=a5", out_valid, out_data);
        end
        n_cmp++; if (beat_cnt !== 4'h0) begin n_fail++; $display("FAIL lat_cnt_c2: got %h want 0", beat_cnt); end
      end
      if (c == 3) begin
        n_cmp++; if (beat_cnt !== 4'h1) begin n_fail++; $display("FAIL lat_cnt_c3: got %h want 1", beat_cnt); end
      end
      if (c == 4) begin
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lat_busy_c4: got %b want 0", busy); end
      end
      next_cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int pulses;
    logic [7:0] exp;
    pulses = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) push(8'(i));
    for (int c = 0; c < 6; c++) begin
      @(negedge rd_clk);
      if (rd_en === 1'b1) pulses++;
      if (c >= 2) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin
          n_fail++; $display("FAIL bp_hold_c%0d: got valid=%b data=%h want valid=1 data=01", c, out_valid, out_data);
        end
      end
      next_cycle();
    end
    n_cmp++; if (pulses != 2) begin n_fail++; $display("FAIL bp_rd_en_pulses: got %0d want 2", pulses); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = 8'(k + 1);
      @(negedge rd_clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp) begin
        n_fail++; $display("FAIL bp_drain_%0d: got valid=%b data=%h want valid=1 data=%h", k, out_valid, out_data, exp);
      end
      next_cycle();
    end
    @(negedge rd_clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_valid: got %b want 0", out_valid); end
    n_cmp++; if (beat_cnt !== 4'h4) begin n_fail++; $display("FAIL bp_beat_cnt: got %h want 4", beat_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    push(8'h55);
    push(8'h66);
    out_ready = 1'b1;
    @(negedge rd_clk);
    n_cmp++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL fl_rd_en_c0: got %b want 1", rd_en); end
    next_cycle();
    flush = 1'b1;
    @(negedge rd_clk);
    n_cmp++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL fl_rd_en_c1: got %b want 0", rd_en); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid_c1: got %b want 0", out_valid); end
    next_cycle();
    flush = 1'b0;
    @(negedge rd_clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fl_state_flush: busy got %b want 1", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid_c2: got %b want 0", out_valid); end
    n_cmp++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL fl_rd_en_c2: got %b want 0", rd_en); end
    next_cycle();
    @(negedge rd_clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fl_busy_c3: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid_c3: got %b want 0", out_valid); end
    next_cycle();
    next_cycle();
    @(negedge rd_clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin
      n_fail++; $display("FAIL fl_next_word: got valid=%b data=%h want valid=1 data=66", out_valid, out_data);
    end
    next_cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_flush_repeat();
    do_reset();
    push(8'h77);
    flush = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge rd_clk);
      n_cmp++; if (rd_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL flr_hold_c%0d: got rd_en=%b busy=%b want 0 0", c, rd_en, busy);
      end
      next_cycle();
    end
    flush = 1'b0;
    @(negedge rd_clk);
    n_cmp++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL flr_resume: got %b want 1", rd_en); end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge rd_clk);
      if (c >= 2 && c <= 18) begin
        exp = 8'(8'h10 + c - 2);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp) begin
          n_fail++; $display("FAIL wrap_stream_c%0d: got valid=%b data=%h want valid=1 data=%h", c, out_valid, out_data, exp);
        end
      end
      if (c == 17) begin
        n_cmp++; if (beat_cnt !== 4'hF) begin n_fail++; $display("FAIL wrap_cnt_f: got %h want f", beat_cnt); end
      end
      if (c == 18) begin
        n_cmp++; if (beat_cnt !== 4'h0) begin n_fail++; $display("FAIL wrap_cnt_0: got %h want 0", beat_cnt); end
      end
      if (c == 19) begin
        n_cmp++; if (beat_cnt !== 4'h1) begin n_fail++; $display("FAIL wrap_cnt_1: got %h want 1", beat_cnt); end
      end
      next_cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    push(8'h11); push(8'h22); push(8'h33); push(8'h07); push(8'h03);
    @(negedge rd_clk);
    next_cycle();
    @(negedge rd_clk);
    next_cycle();
    out_ready = 1'b1;
    @(negedge rd_clk);
    next_cycle();
    out_ready = 1'b0;
    @(negedge rd_clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      n_fail++; $display("FAIL mr_head_c3: got valid=%b data=%h want valid=1 data=22", out_valid, out_data);
    end
    next_cycle();
    rd_rst = 1'b1;
    @(negedge rd_clk);
    n_cmp++; if (beat_cnt !== 4'h1) begin n_fail++; $display("FAIL mr_cnt_before: got %h want 1", beat_cnt); end
    n_cmp++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL mr_rd_en_rst: got %b want 0", rd_en); end
    next_cycle();
    rd_rst = 1'b0;
    @(negedge rd_clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid_after: got %b want 0", out_valid); end
    n_cmp++; if (beat_cnt !== 4'h0) begin n_fail++; $display("FAIL mr_cnt_after: got %h want 0", beat_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy_after: got %b want 0", busy); end
    next_cycle();
    next_cycle();
    out_ready = 1'b1;
    @(negedge rd_clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h07) begin
      n_fail++; $display("FAIL mr_word_07: got valid=%b data=%h want valid=1 data=07", out_valid, out_data);
    end
`ifdef RD_PARITY_EN
    n_cmp++; if (out_parity !== 1'b1) begin n_fail++; $display("FAIL par_07: got %b want 1", out_parity); end
`endif
    next_cycle();
    @(negedge rd_clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin
      n_fail++; $display("FAIL mr_word_03: got valid=%b data=%h want valid=1 data=03", out_valid, out_data);
    end
`ifdef RD_PARITY_EN
    n_cmp++; if (out_parity !== 1'b0) begin n_fail++; $display("FAIL par_03: got %b want 0", out_parity); end
`endif
    next_cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    rd_rst    = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_flush();
    test_flush_repeat();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
